// File: rtl/nfault_arbiter.sv
// Fault aggregator for the shared open-drain nFault line: sticky status bits,
// first-fault capture, episode counting and a pulse/recovery sequencer.
module nfault_arbiter #(
    parameter int NUM_SUBSYSTEMS    = 8,
    parameter int MIN_ASSERT_CYCLES = 50,
    parameter int RECOVER_CYCLES    = 4,
    parameter int ID_WIDTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SUBSYSTEMS-1:0] fault_req,
    input  logic                      clear_strobe,
    input  logic [NUM_SUBSYSTEMS-1:0] clear_mask,
    output logic                      nFault_drive_low,
    output logic [NUM_SUBSYSTEMS-1:0] fault_status,
    output logic [ID_WIDTH-1:0]       first_fault_id,
    output logic                      first_fault_valid,
    output logic [7:0]                fault_count
);

    localparam int MAX_CYCLES = (MIN_ASSERT_CYCLES > RECOVER_CYCLES) ?
                                MIN_ASSERT_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLD    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                    state_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [NUM_SUBSYSTEMS-1:0] status_reg;
    logic [NUM_SUBSYSTEMS-1:0] status_next;
    logic [ID_WIDTH-1:0]       id_reg;
    logic [ID_WIDTH-1:0]       lowest_id_next;
    logic                      valid_reg;
    logic [7:0]                episodes_reg;

    // A live request always wins over a clear of the same bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SUBSYSTEMS; gi++) begin : g_sticky
            assign status_next[gi] = fault_req[gi] |
                                     (status_reg[gi] & ~(clear_strobe & clear_mask[gi]));
        end
    endgenerate

    always_comb begin
        lowest_id_next = '0;
        for (int i = NUM_SUBSYSTEMS - 1; i >= 0; i--) begin
            if (status_next[i]) begin
                lowest_id_next = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_reg   <= '0;
            id_reg       <= '0;
            valid_reg    <= 1'b0;
            episodes_reg <= 8'd0;
            state_reg    <= S_IDLE;
            count_reg    <= '0;
        end else begin
            status_reg <= status_next;

            if ((status_reg == '0) && (status_next != '0)) begin
                id_reg    <= lowest_id_next;
                valid_reg <= 1'b1;
            end else if (status_next == '0) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (status_reg != '0) begin
                        count_reg <= CNT_W'(MIN_ASSERT_CYCLES - 1);
                        state_reg <= S_ASSERT;
                        if (episodes_reg != 8'hFF) begin
                            episodes_reg <= episodes_reg + 8'd1;
                        end
                    end
                end
                // Leaving on the decrement to zero makes ASSERT plus the single
                // HOLD cycle exactly MIN_ASSERT_CYCLES when faults clear early.
                S_ASSERT: begin
                    if (count_reg <= CNT_W'(1)) begin
                        count_reg <= '0;
                        state_reg <= S_HOLD;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (status_reg == '0) begin
                        count_reg <= CNT_W'(RECOVER_CYCLES - 1);
                        state_reg <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    if (count_reg == '0) begin
                        state_reg <= S_IDLE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: begin
                    count_reg <= '0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign nFault_drive_low  = (state_reg == S_ASSERT) || (state_reg == S_HOLD);
    assign fault_status      = status_reg;
    assign first_fault_id    = id_reg;
    assign first_fault_valid = valid_reg;
    assign fault_count       = episodes_reg;

endmodule
